// File: rtl/run_ctrl_pkg.sv
// Shared types and default signature constants for the simulation run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } run_state_t;

    localparam int unsigned DEF_PASS_ADDR = 84;
    localparam int unsigned DEF_PASS_DATA = 7;

endpackage

// File: rtl/run_ctrl_trace_buf.sv
// Ring of the most recent RUN-state data-memory writes with a combinational
// read port indexed backwards from the newest entry.
module run_ctrl_trace_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_adr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_adr,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] adr_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [IDX_W-1:0]  wptr_q;
    logic [IDX_W:0]    fill_q;
    logic [IDX_W-1:0]  rd_slot;
    logic              rd_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            fill_q <= '0;
        end else if (wr_en) begin
            wptr_q <= wptr_q + IDX_W'(1);
            if (fill_q != (IDX_W + 1)'(DEPTH)) begin
                fill_q <= fill_q + (IDX_W + 1)'(1);
            end
        end
    end

    // Storage needs no reset: slots beyond the fill level are masked on read.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            adr_mem[wptr_q]  <= wr_adr;
            data_mem[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_slot = wptr_q - IDX_W'(1) - rd_idx;
        rd_hit  = ({1'b0, rd_idx} < fill_q);
        rd_adr  = rd_hit ? adr_mem[rd_slot]  : '0;
        rd_data = rd_hit ? data_mem[rd_slot] : '0;
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for program-level MIPS benches: core reset sequencing, signature
// watch, cycle timeout. Optional write trace ring enabled by RUN_CTRL_TRACE_EN.
module sim_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       CNT_W          = 16,
    parameter int unsigned       RESET_CYCLES   = 2,
    parameter int unsigned       TIMEOUT_CYCLES = 100,
    parameter logic [ADDR_W-1:0] PASS_ADDR      = ADDR_W'(DEF_PASS_ADDR),
    parameter logic [DATA_W-1:0] PASS_DATA      = DATA_W'(DEF_PASS_DATA),
    parameter bit                HALT_ON_DONE   = 1'b1,
    parameter int unsigned       TRACE_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           restart,
    input  logic                           memwrite,
    input  logic [ADDR_W-1:0]              dataadr,
    input  logic [DATA_W-1:0]              writedata,
    output logic                           core_reset,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               write_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [ADDR_W-1:0]              trace_adr,
    output logic [DATA_W-1:0]              trace_data
);

    localparam int unsigned     HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    run_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  write_q, write_d;
    logic              sig_hit;
    logic              timeout_hit;
    logic              run_write;

    assign sig_hit     = memwrite && (dataadr == PASS_ADDR);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_q == TO_LAST);
    assign run_write   = (state_q == RUN) && memwrite && !restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HOLD;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_q      <= '0;
            write_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            cycle_q      <= cycle_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        cycle_d      = cycle_q;
        write_d      = write_q;

        if (restart) begin
            state_d      = HOLD;
            hold_d       = '0;
            core_reset_d = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            timeout_d    = 1'b0;
            cycle_d      = '0;
            write_d      = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    core_reset_d = 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_d      = RUN;
                        hold_d       = '0;
                        core_reset_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RUN: begin
                    core_reset_d = 1'b0;
                    if (cycle_q != CNT_MAX) begin
                        cycle_d = cycle_q + CNT_W'(1);
                    end
                    if (memwrite && (write_q != CNT_MAX)) begin
                        write_d = write_q + CNT_W'(1);
                    end
                    // Signature write outranks a timeout landing in the same cycle.
                    if (sig_hit && (writedata == PASS_DATA)) begin
                        state_d      = PASS;
                        pass_d       = 1'b1;
                        done_d       = 1'b1;
                        core_reset_d = HALT_ON_DONE;
                    end else if (sig_hit) begin
                        state_d      = FAIL;
                        fail_d       = 1'b1;
                        done_d       = 1'b1;
                        core_reset_d = HALT_ON_DONE;
                    end else if (timeout_hit) begin
                        state_d      = TIMEOUT;
                        timeout_d    = 1'b1;
                        done_d       = 1'b1;
                        core_reset_d = HALT_ON_DONE;
                    end
                end
                PASS, FAIL, TIMEOUT: begin
                    core_reset_d = HALT_ON_DONE;
                end
                default: begin
                    state_d      = HOLD;
                    hold_d       = '0;
                    core_reset_d = 1'b1;
                end
            endcase
        end
    end

    assign core_reset  = core_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;
    assign write_count = write_q;

`ifdef RUN_CTRL_TRACE_EN
    run_ctrl_trace_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .reset   (reset),
        .clear   (restart),
        .wr_en   (run_write),
        .wr_adr  (dataadr),
        .wr_data (writedata),
        .rd_idx  (trace_idx),
        .rd_adr  (trace_adr),
        .rd_data (trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_idx, run_write};
    assign trace_adr    = '0;
    assign trace_data   = '0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: verdicts are checked by a monitor on each done rise.
module tb_sim_run_ctrl;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        core_reset;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] write_count;
    logic [2:0]  trace_idx;
    logic [31:0] trace_adr;
    logic [31:0] trace_data;

    sim_run_ctrl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .CNT_W          (16),
        .RESET_CYCLES   (2),
        .TIMEOUT_CYCLES (100),
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd7),
        .HALT_ON_DONE   (1'b1),
        .TRACE_DEPTH    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .core_reset  (core_reset),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .write_count (write_count),
        .trace_idx   (trace_idx),
        .trace_adr   (trace_adr),
        .trace_data  (trace_data)
    );

    // Rising edges at 10, 20, 30 ...; stimulus and sampling on falling edges.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic        core_reset;
        logic [15:0] wc;
        logic [15:0] cc;
    } verdict_t;

    verdict_t exp_q[$];
    verdict_t mon_e;
    int       n_checks = 0;
    int       n_fail   = 0;
    logic     done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_verdict(input string name, input logic p, input logic f, input logic t,
                                  input logic [15:0] wc, input logic [15:0] cc);
        verdict_t e;
        e.name       = name;
        e.pass       = p;
        e.fail       = f;
        e.timeout    = t;
        e.core_reset = 1'b1;
        e.wc         = wc;
        e.cc         = cc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_verdict_done", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_pass"}, pass, mon_e.pass);
                chk({mon_e.name, "_fail"}, fail, mon_e.fail);
                chk({mon_e.name, "_timeout"}, timeout, mon_e.timeout);
                chk({mon_e.name, "_core_reset"}, core_reset, mon_e.core_reset);
                chk({mon_e.name, "_write_count"}, write_count, mon_e.wc);
                chk({mon_e.name, "_cycle_count"}, cycle_count, mon_e.cc);
            end
        end
        done_prev <= done;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write1(input logic [31:0] adr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = data;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk({name, "_wait_expired"}, done, 1);
    endtask

    // Leaves the bench in RUN cycle 0.
    task automatic do_restart(input string name);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({name, "_restart_core_reset"}, core_reset, 1);
        chk({name, "_restart_done"}, done, 0);
        cycles(2);
        chk({name, "_run_core_reset"}, core_reset, 0);
        chk({name, "_run_cycle0"}, cycle_count, 0);
    endtask

    initial begin
        reset     = 1'b0;
        restart   = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        trace_idx = '0;

        // Reset state
        #3;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", {pass, fail, timeout}, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_write_count", write_count, 0);
        #22;
        reset = 1'b1;
        #1;
        @(negedge clk);
        chk("hold_edge1_core_reset", core_reset, 1);
        @(negedge clk);
        chk("hold_edge2_core_reset", core_reset, 0);
        chk("run_entry_cycle_count", cycle_count, 0);

        // Pass at RUN cycle 20, later writes ignored
        cycles(20);
        chk("pass_pre_cycle_count", cycle_count, 20);
        expect_verdict("pass20", 1, 0, 0, 16'd1, 16'd21);
        write1(32'd84, 32'd7);
        write1(32'd84, 32'd5);
        cycles(1);
        chk("pass_sticky_pass", pass, 1);
        chk("pass_sticky_fail", fail, 0);
        chk("pass_frozen_wc", write_count, 1);
        chk("pass_frozen_cc", cycle_count, 21);
        chk("pass_halt_core_reset", core_reset, 1);

        // Non-signature write, then fail
        do_restart("fail");
        cycles(3);
        write1(32'd80, 32'd7);
        chk("nonsig_no_verdict", done, 0);
        chk("nonsig_write_count", write_count, 1);
        cycles(1);
        expect_verdict("fail", 0, 1, 0, 16'd2, 16'd6);
        write1(32'd84, 32'd5);
        cycles(1);

        // Timeout with no writes
        do_restart("to");
        expect_verdict("timeout", 0, 0, 1, 16'd0, 16'd100);
        wait_done("timeout", 120);
        cycles(1);

        // Signature write in the final RUN cycle beats the timeout
        do_restart("to_pass");
        cycles(99);
        chk("to_pass_pre_cc", cycle_count, 99);
        expect_verdict("to_pass", 1, 0, 0, 16'd1, 16'd100);
        write1(32'd84, 32'd7);
        cycles(1);

        // Restart together with a signature write
        do_restart("rs");
        cycles(5);
        restart   = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 32'd84;
        writedata = 32'd7;
        @(negedge clk);
        restart  = 1'b0;
        memwrite = 1'b0;
        chk("rs_done", done, 0);
        chk("rs_pass", pass, 0);
        chk("rs_core_reset", core_reset, 1);
        chk("rs_cycle_count", cycle_count, 0);
        chk("rs_write_count", write_count, 0);
        cycles(2);
        chk("rs_rerun_core_reset", core_reset, 0);
        cycles(4);
        chk("rs_rerun_cc", cycle_count, 4);
        chk("rs_rerun_done", done, 0);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("async_core_reset", core_reset, 1);
        chk("async_cycle_count", cycle_count, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("async_rerun_core_reset", core_reset, 0);

        // Trace ring
        for (int i = 0; i < 10; i++) begin
            write1(32'(4 * i), 32'(i));
        end
        chk("trace_write_count", write_count, 10);
        chk("trace_no_verdict", done, 0);
`ifdef RUN_CTRL_TRACE_EN
        trace_idx = 3'd0;
        #1;
        chk("trace_idx0_adr", trace_adr, 36);
        chk("trace_idx0_data", trace_data, 9);
        trace_idx = 3'd7;
        #1;
        chk("trace_idx7_adr", trace_adr, 8);
        chk("trace_idx7_data", trace_data, 2);
        do_restart("trace");
        trace_idx = 3'd0;
        #1;
        chk("trace_cleared_adr", trace_adr, 0);
        chk("trace_cleared_data", trace_data, 0);
`else
        trace_idx = 3'd0;
        #1;
        chk("trace_off_idx0_adr", trace_adr, 0);
        chk("trace_off_idx0_data", trace_data, 0);
        trace_idx = 3'd7;
        #1;
        chk("trace_off_idx7_adr", trace_adr, 0);
        chk("trace_off_idx7_data", trace_data, 0);
`endif

        cycles(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

endmodule
